// File: rtl/riscv_pkg.sv
// Shared constants for the decode stage: opcodes, ID-slot FSM states, NOP word.
// Also holds the instruction-type flag bundle and a saturating increment helper.
package riscv_pkg;

  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC = 7'b0010111;
  localparam logic [6:0]  OPC_I     = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_S     = 7'b0100011;
  localparam logic [6:0]  OPC_B     = 7'b1100011;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;
  localparam logic [6:0]  OPC_JALR  = 7'b1100111;
  localparam logic [6:0]  OPC_R     = 7'b0110011;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HOLD  = 2'd2
  } id_state_e;

  typedef struct packed {
    logic is_lui;
    logic is_auipc;
    logic is_i;
    logic is_iload;
    logic is_s;
    logic is_b;
    logic is_jal;
    logic is_jalr;
    logic is_r;
  } inst_flags_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    logic [15:0] res;
    if (val == 16'hFFFF) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/decode_stage_ctrl_if.sv
// Fetch-to-ID handshake, EX feedback and ID outputs bundled for the decode stage.
// The slave modport is the decode stage; the master modport drives it.
interface decode_stage_ctrl_if;

  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        ex_ready;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        is_LUI;
  logic        is_AUIPC;
  logic        is_I_type;
  logic        is_S_type;
  logic        is_Iload_type;
  logic        is_B_type;
  logic        is_JAL;
  logic        is_JALR;
  logic        is_R_type;
  logic        illegal;
  logic [15:0] bubble_cnt;

  modport master (
    output if_valid, if_inst, if_pc, ex_ready, ex_is_load, ex_rd, flush,
    input  if_ready, id_valid, id_inst, id_pc, id_rs1, id_rs2, id_rd,
    input  is_LUI, is_AUIPC, is_I_type, is_S_type, is_Iload_type, is_B_type,
    input  is_JAL, is_JALR, is_R_type, illegal, bubble_cnt
  );

  modport slave (
    input  if_valid, if_inst, if_pc, ex_ready, ex_is_load, ex_rd, flush,
    output if_ready, id_valid, id_inst, id_pc, id_rs1, id_rs2, id_rd,
    output is_LUI, is_AUIPC, is_I_type, is_S_type, is_Iload_type, is_B_type,
    output is_JAL, is_JALR, is_R_type, illegal, bubble_cnt
  );

endinterface

// File: rtl/decode_stage_ctrl_inst_type_decode.sv
// Pure opcode decoder: one-hot type flags, illegal marker and source-register usage.
// Unknown opcodes are treated as reading rs1 so a hazard is never missed.
module inst_type_decode
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  output inst_flags_t flags,
  output logic        illegal,
  output logic        rs1_used,
  output logic        rs2_used
);

  // Opcode to type flag lookup
  always_comb begin
    flags   = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:   flags.is_lui   = 1'b1;
      OPC_AUIPC: flags.is_auipc = 1'b1;
      OPC_I:     flags.is_i     = 1'b1;
      OPC_LOAD:  flags.is_iload = 1'b1;
      OPC_S:     flags.is_s     = 1'b1;
      OPC_B:     flags.is_b     = 1'b1;
      OPC_JAL:   flags.is_jal   = 1'b1;
      OPC_JALR:  flags.is_jalr  = 1'b1;
      OPC_R:     flags.is_r     = 1'b1;
      default:   illegal        = 1'b1;
    endcase
    rs1_used = !(flags.is_lui || flags.is_auipc || flags.is_jal);
    rs2_used = flags.is_s || flags.is_b || flags.is_r;
  end

endmodule

// File: rtl/decode_stage_ctrl.sv
// ID pipeline register with load-use stall control (EMPTY/FULL/HOLD) and bubble count.
// id_valid and if_ready are combinational so a hazard squashes issue in the same cycle.
module decode_stage_ctrl
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  decode_stage_ctrl_if.slave bus
);

  id_state_e   state_r;
  id_state_e   state_nxt_s;
  logic [31:0] inst_r;
  logic [31:0] pc_r;
  logic [15:0] bubble_cnt_r;
  logic        hazard_s;
  logic        if_ready_s;
  logic        accept_s;
  logic        id_valid_s;
  inst_flags_t flags_s;
  logic        illegal_s;
  logic        rs1_used_s;
  logic        rs2_used_s;

  inst_type_decode u_dec (
    .opcode   (inst_r[6:0]),
    .flags    (flags_s),
    .illegal  (illegal_s),
    .rs1_used (rs1_used_s),
    .rs2_used (rs2_used_s)
  );

  // Load-use hazard detection and fetch handshake
  always_comb begin
    hazard_s = 1'b0;
    if ((state_r == ST_FULL) && bus.ex_is_load && (bus.ex_rd != 5'd0)) begin
      hazard_s = (rs1_used_s && (bus.ex_rd == inst_r[19:15])) ||
                 (rs2_used_s && (bus.ex_rd == inst_r[24:20]));
    end else begin
      hazard_s = 1'b0;
    end
    if_ready_s = !rst && !bus.flush &&
                 ((state_r == ST_EMPTY) ||
                  ((state_r == ST_FULL) && bus.ex_ready && !hazard_s));
    accept_s   = bus.if_valid && if_ready_s;
    id_valid_s = (state_r == ST_FULL) && !hazard_s;
  end

  // Next-state selection; flush overrides every state
  always_comb begin
    state_nxt_s = state_r;
    if (bus.flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_nxt_s = accept_s ? ST_FULL : ST_EMPTY;
        ST_FULL: begin
          if (hazard_s) begin
            state_nxt_s = ST_HOLD;
          end else if (bus.ex_ready) begin
            state_nxt_s = accept_s ? ST_FULL : ST_EMPTY;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        ST_HOLD:  state_nxt_s = ST_FULL;
        default:  state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // State, instruction/PC capture and bubble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      inst_r       <= NOP_INST;
      pc_r         <= 32'd0;
      bubble_cnt_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        inst_r <= bus.if_inst;
        pc_r   <= bus.if_pc;
      end
      if ((state_r == ST_FULL) && hazard_s && !bus.flush) begin
        bubble_cnt_r <= sat_inc16(bubble_cnt_r);
      end
    end
  end

  assign bus.if_ready      = if_ready_s;
  assign bus.id_valid      = id_valid_s;
  assign bus.id_inst       = inst_r;
  assign bus.id_pc         = pc_r;
  assign bus.id_rs1        = inst_r[19:15];
  assign bus.id_rs2        = inst_r[24:20];
  assign bus.id_rd         = inst_r[11:7];
  assign bus.bubble_cnt    = bubble_cnt_r;
  // Type outputs are squashed whenever nothing is issued toward EX
  assign bus.is_LUI        = id_valid_s && flags_s.is_lui;
  assign bus.is_AUIPC      = id_valid_s && flags_s.is_auipc;
  assign bus.is_I_type     = id_valid_s && flags_s.is_i;
  assign bus.is_Iload_type = id_valid_s && flags_s.is_iload;
  assign bus.is_S_type     = id_valid_s && flags_s.is_s;
  assign bus.is_B_type     = id_valid_s && flags_s.is_b;
  assign bus.is_JAL        = id_valid_s && flags_s.is_jal;
  assign bus.is_JALR       = id_valid_s && flags_s.is_jalr;
  assign bus.is_R_type     = id_valid_s && flags_s.is_r;
  assign bus.illegal       = id_valid_s && illegal_s;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Bench for decode_stage_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a slot-occupancy model of the ID register.
module tb_decode_stage_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_ctrl_if bus ();
  decode_stage_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [6:0] opc_tab [9] = '{7'h37, 7'h17, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33};

  // Model: does the slot hold an instruction, and is it serving its one bubble cycle
  logic        m_have = 1'b0;
  logic        m_bubble = 1'b0;
  logic [31:0] m_inst = 32'h0000_0013;
  logic [31:0] m_pc = 32'd0;
  int          m_cnt = 0;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit preload_now = 1'b0;
  int step = 0;

  function automatic int type_idx(input logic [31:0] inst);
    for (int k = 0; k < 9; k++) if (inst[6:0] == opc_tab[k]) return k;
    return 9;
  endfunction

  function automatic bit model_hazard();
    int  t;
    bit  u1, u2;
    t  = type_idx(m_inst);
    u1 = !(t == 0 || t == 1 || t == 6);
    u2 = (t == 4 || t == 5 || t == 8);
    return m_have && !m_bubble && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
           ((u1 && bus.ex_rd == m_inst[19:15]) || (u2 && bus.ex_rd == m_inst[24:20]));
  endfunction

  // Model update on the clock edge
  always @(posedge clk) begin
    if (rst) begin
      m_have <= 1'b0; m_bubble <= 1'b0; m_inst <= 32'h0000_0013; m_pc <= 32'd0; m_cnt <= 0;
    end else begin
      if (preload_now) m_cnt <= 65533;
      if (bus.flush) begin
        m_have <= 1'b0; m_bubble <= 1'b0;
      end else if (m_have && m_bubble) begin
        m_bubble <= 1'b0;
      end else if (m_have && model_hazard()) begin
        m_bubble <= 1'b1;
        m_cnt <= ((preload_now ? 65533 : m_cnt) + 1 > 65535) ? 65535 : (preload_now ? 65533 : m_cnt) + 1;
      end else if (m_have && !bus.ex_ready) begin
        m_have <= 1'b1;
      end else if (bus.if_valid) begin
        m_have <= 1'b1; m_inst <= bus.if_inst; m_pc <= bus.if_pc;
      end else begin
        m_have <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  logic       e_hz, e_full, e_valid, e_ready;
  logic [9:0] e_flags, a_flags;

  // Single compare process: model check every cycle plus literal pins per directed step
  always @(negedge clk) begin
    if (chk_en) begin
      e_hz    = model_hazard();
      e_full  = m_have && !m_bubble;
      e_valid = e_full && !e_hz;
      e_ready = !rst && !bus.flush && (!m_have || (e_full && bus.ex_ready && !e_hz));
      e_flags = e_valid ? (10'd1 << type_idx(m_inst)) : 10'd0;
      a_flags = {bus.illegal, bus.is_R_type, bus.is_JALR, bus.is_JAL, bus.is_B_type,
                 bus.is_S_type, bus.is_Iload_type, bus.is_I_type, bus.is_AUIPC, bus.is_LUI};
      chk("id_valid", 32'(bus.id_valid), 32'(e_valid));
      chk("if_ready", 32'(bus.if_ready), 32'(e_ready));
      chk("id_inst", bus.id_inst, m_inst);
      chk("id_pc", bus.id_pc, m_pc);
      chk("fields", {17'd0, bus.id_rs1, bus.id_rs2, bus.id_rd},
          {17'd0, m_inst[19:15], m_inst[24:20], m_inst[11:7]});
      chk("flags", 32'(a_flags), 32'(e_flags));
      chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(m_cnt));
      case (step)
        1: begin
          chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
          chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
          chk("rst_id_inst", bus.id_inst, 32'h0000_0013);
          chk("rst_model_inst", m_inst, 32'h0000_0013);
          chk("rst_id_pc", bus.id_pc, 32'd0);
          chk("rst_cnt", 32'(bus.bubble_cnt), 32'd0);
          chk("rst_flags", 32'(a_flags), 32'd0);
        end
        2: chk("empty_if_ready", 32'(bus.if_ready), 32'd1);
        3: begin
          chk("addi_valid", 32'(bus.id_valid), 32'd1);
          chk("addi_flags", 32'(a_flags), 32'h004);
          chk("addi_rd", 32'(bus.id_rd), 32'd1);
          chk("addi_pc", bus.id_pc, 32'h100);
        end
        4: begin
          chk("hz_valid", 32'(bus.id_valid), 32'd0);
          chk("hz_inst", bus.id_inst, 32'h0020_8133);
          chk("hz_cnt", 32'(bus.bubble_cnt), 32'd0);
        end
        5: begin
          chk("hold_valid", 32'(bus.id_valid), 32'd0);
          chk("hold_cnt", 32'(bus.bubble_cnt), 32'd1);
          chk("hold_model_cnt", 32'(m_cnt), 32'd1);
        end
        6: begin
          chk("resume_valid", 32'(bus.id_valid), 32'd1);
          chk("resume_inst", bus.id_inst, 32'h0020_8133);
        end
        7: chk("rd0_valid", 32'(bus.id_valid), 32'd1);
        8: begin
          chk("stall_cnt", 32'(bus.bubble_cnt), 32'd1);
          chk("stall_ready", 32'(bus.if_ready), 32'd0);
          chk("stall_inst", bus.id_inst, 32'h0020_8133);
        end
        9: chk("flush_ready", 32'(bus.if_ready), 32'd0);
        10: chk("flush_valid", 32'(bus.id_valid), 32'd0);
        11: begin
          chk("lui_valid", 32'(bus.id_valid), 32'd1);
          chk("lui_flags", 32'(a_flags), 32'h001);
        end
        12: chk("lui_rd0_valid", 32'(bus.id_valid), 32'd1);
        13: begin
          chk("sat_cnt", 32'(bus.bubble_cnt), 32'h0000_FFFF);
          chk("sat_model_cnt", 32'(m_cnt), 32'd65535);
        end
        default: ;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int sel;
    w = $urandom();
    w[19:15] = 5'($urandom_range(3));
    w[24:20] = 5'($urandom_range(3));
    sel = $urandom_range(10);
    if (sel < 9) w[6:0] = opc_tab[sel];
    return w;
  endfunction

  initial begin
    bus.if_valid = 1'b0; bus.if_inst = 32'd0; bus.if_pc = 32'd0; bus.ex_ready = 1'b0;
    bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0; bus.flush = 1'b0;
    cyc(); chk_en = 1'b1; step = 1;
    cyc();
    rst = 1'b0; bus.if_valid = 1'b1; bus.if_inst = 32'h0050_0093; bus.if_pc = 32'h100;
    bus.ex_ready = 1'b1; step = 2;
    cyc(); bus.if_inst = 32'h0020_8133; bus.if_pc = 32'h104; step = 3;
    cyc(); bus.if_valid = 1'b0; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd1; step = 4;
    cyc(); bus.ex_is_load = 1'b0; step = 5;
    cyc(); bus.ex_ready = 1'b0; step = 6;
    cyc(); bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0; step = 7;
    repeat (3) begin cyc(); step = 8; end
    cyc(); bus.flush = 1'b1; bus.if_valid = 1'b1; bus.if_inst = 32'h0000_0033; bus.if_pc = 32'h200; step = 9;
    cyc(); bus.flush = 1'b0; bus.if_valid = 1'b0; bus.ex_is_load = 1'b0; step = 10;
    cyc(); bus.if_valid = 1'b1; bus.if_inst = 32'h1234_5037; bus.if_pc = 32'h300; step = 0;
    cyc(); bus.if_valid = 1'b0; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd8; step = 11;
    cyc(); bus.ex_rd = 5'd0; step = 12;
    cyc(); bus.ex_ready = 1'b1; bus.ex_is_load = 1'b0; step = 0;
    cyc(); bus.if_valid = 1'b1; bus.if_inst = 32'h0020_8133; bus.if_pc = 32'h400;
    cyc(); bus.if_valid = 1'b0; bus.ex_ready = 1'b0; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd2;
    @(negedge clk); #1;
    force dut.bubble_cnt_r = 16'hFFFD;
    #1;
    release dut.bubble_cnt_r;
    preload_now = 1'b1;
    cyc(); preload_now = 1'b0;
    repeat (6) cyc();
    step = 13;
    cyc(); step = 0;
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(199) == 0);
      bus.flush      = ($urandom_range(19) == 0);
      bus.if_valid   = ($urandom_range(9) < 6);
      bus.if_inst    = rand_inst();
      bus.if_pc      = $urandom() & 32'hFFFF_FFFC;
      bus.ex_ready   = ($urandom_range(9) < 7);
      bus.ex_is_load = ($urandom_range(9) < 4);
      bus.ex_rd      = 5'($urandom_range(3));
      cyc();
    end
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
